// File: rtl/tree_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// tree_spawn_scheduler
//
// Sequences a pool of falling-tree obstacle slots for the VGA game layer. On
// every enabled frame it moves live trees down by the current fall speed, and
// it retires trees that pass the bottom edge or are hit by the player. It
// spawns new trees at pseudo-random X positions on a fixed frame cadence and
// raises the fall speed level by level. All vertical fixed-point arithmetic
// lives here, so the drawing objects only ever see pixel positions.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   startOfFrame one-cycle pulse per VGA frame
//   enable       game running; low freezes everything except the LFSR
//   hitIn        per-slot player collision (may be held for several cycles)
//   treeActive   per-slot live flag
//   treeX        signed topLeftX per slot, slot i at bits [11i+10:11i]
//   treeY        topLeftY per slot (fixed-point Y >> 6), same packing
//   passedPulse  one cycle when one or more trees leave the bottom edge
//   hitPulse     one cycle when one or more trees are cleared by a hit
//   speedLevel   current speed level, saturating at 15
// -----------------------------------------------------------------------------
module tree_spawn_scheduler #(
  parameter int          NUM_SLOTS    = 4,
  parameter int          SPAWN_FRAMES = 60,
  parameter int          BASE_SPEED   = 100,
  parameter int          SPEED_STEP   = 16,
  parameter int          MAX_SPEED    = 320,
  parameter int          LEVEL_FRAMES = 600,
  parameter int          EXIT_Y       = 480,
  parameter int          X_MIN        = 32,
  parameter int          X_SPAN       = 508,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     startOfFrame,
  input  logic                     enable,
  input  logic [NUM_SLOTS-1:0]     hitIn,
  output logic [NUM_SLOTS-1:0]     treeActive,
  output logic [NUM_SLOTS*11-1:0]  treeX,
  output logic [NUM_SLOTS*11-1:0]  treeY,
  output logic                     passedPulse,
  output logic                     hitPulse,
  output logic [3:0]               speedLevel
);

  localparam logic [16:0] EXIT_FP     = 17'(EXIT_Y * 64);
  localparam logic [15:0] SPAWN_LAST  = 16'(SPAWN_FRAMES - 1);
  localparam logic [15:0] LEVEL_LAST  = 16'(LEVEL_FRAMES - 1);
  // Galois feedback mask for taps 16,14,13,11 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  // Speed increase saturating at MAX_SPEED.
  function automatic logic [15:0] sat_speed(input logic [15:0] s);
    logic [16:0] sum;
    sum = {1'b0, s} + 17'(SPEED_STEP);
    if (sum > 17'(MAX_SPEED)) return 16'(MAX_SPEED);
    return sum[15:0];
  endfunction

  // Level increment saturating at 15.
  function automatic logic [3:0] sat_level(input logic [3:0] l);
    if (l == 4'hF) return l;
    return l + 4'd1;
  endfunction

  // Fold a 9-bit random value into 0..X_SPAN and offset by X_MIN.
  function automatic logic signed [10:0] wrap_x(input logic [8:0] rin);
    logic [9:0] r;
    r = {1'b0, rin};
    if (r > 10'(X_SPAN)) r = r - 10'(X_SPAN) - 10'd1;
    return $signed(11'(X_MIN) + {1'b0, r});
  endfunction

  // Registered state (single stage: everything below updates at one edge)
  logic [NUM_SLOTS-1:0]  active_p1;
  logic signed [10:0]    x_p1   [NUM_SLOTS];
  logic [15:0]           yfp_p1 [NUM_SLOTS];
  logic [15:0]           speed_p1;
  logic [15:0]           timer_p1;
  logic [15:0]           lvl_cnt_p1;
  logic [3:0]            level_p1;
  logic [15:0]           lfsr_p1;
  logic                  passed_p1;
  logic                  hit_p1;

  // Stage p0: next-state decisions from inputs and registered state
  logic                  frame_go_p0;
  logic [NUM_SLOTS-1:0]  hit_clr_p0;
  logic [NUM_SLOTS-1:0]  exit_p0;
  logic [16:0]           next_y_p0 [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  spawn_sel_p0;
  logic                  free_found_p0;
  logic                  spawn_go_p0;
  logic signed [10:0]    spawn_x_p0;
  logic [15:0]           lfsr_next_p0;

  always_comb begin
    frame_go_p0   = startOfFrame & enable;
    hit_clr_p0    = enable ? (hitIn & active_p1) : '0;
    exit_p0       = '0;
    spawn_sel_p0  = '0;
    free_found_p0 = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      next_y_p0[i] = {1'b0, yfp_p1[i]} + {1'b0, speed_p1};
      // A hit in the same cycle takes precedence over leaving the screen.
      exit_p0[i] = frame_go_p0 & active_p1[i] & ~hit_clr_p0[i] &
                   (next_y_p0[i] > EXIT_FP);
      // Lowest free slot, judged on the mask from before this edge so a
      // slot freed this frame is not refilled until the next one.
      if (!free_found_p0 && !active_p1[i]) begin
        spawn_sel_p0[i] = 1'b1;
        free_found_p0   = 1'b1;
      end
    end
    spawn_go_p0  = frame_go_p0 & (timer_p1 == SPAWN_LAST) & free_found_p0;
    spawn_x_p0   = wrap_x(lfsr_p1[8:0]);
    lfsr_next_p0 = {1'b0, lfsr_p1[15:1]} ^ (lfsr_p1[0] ? LFSR_TAPS : 16'h0000);
  end

  // Stage p1: state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      active_p1  <= '0;
      speed_p1   <= 16'(BASE_SPEED);
      timer_p1   <= '0;
      lvl_cnt_p1 <= '0;
      level_p1   <= '0;
      lfsr_p1    <= LFSR_SEED;
      passed_p1  <= 1'b0;
      hit_p1     <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_p1[i]   <= '0;
        yfp_p1[i] <= '0;
      end
    end else begin
      // The LFSR keeps running while the game is frozen.
      lfsr_p1   <= lfsr_next_p0;
      hit_p1    <= |hit_clr_p0;
      passed_p1 <= |exit_p0;

      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (hit_clr_p0[i]) begin
          active_p1[i] <= 1'b0;
        end else if (frame_go_p0 && active_p1[i]) begin
          if (exit_p0[i]) begin
            active_p1[i] <= 1'b0;
            yfp_p1[i]    <= '0;
          end else begin
            yfp_p1[i]    <= next_y_p0[i][15:0];
          end
        end else if (spawn_go_p0 && spawn_sel_p0[i]) begin
          active_p1[i] <= 1'b1;
          yfp_p1[i]    <= '0;
          x_p1[i]      <= spawn_x_p0;
        end
      end

      if (frame_go_p0) begin
        // Timer parks at its terminal value until a slot is free.
        if (timer_p1 < SPAWN_LAST)  timer_p1 <= timer_p1 + 16'd1;
        else if (spawn_go_p0)       timer_p1 <= '0;

        if (lvl_cnt_p1 == LEVEL_LAST) begin
          lvl_cnt_p1 <= '0;
          speed_p1   <= sat_speed(speed_p1);
          level_p1   <= sat_level(level_p1);
        end else begin
          lvl_cnt_p1 <= lvl_cnt_p1 + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign treeX[11*g +: 11] = x_p1[g];
    assign treeY[11*g +: 11] = {1'b0, yfp_p1[g][15:6]};
  end

  assign treeActive  = active_p1;
  assign passedPulse = passed_p1;
  assign hitPulse    = hit_p1;
  assign speedLevel  = level_p1;

endmodule

// File: tb/tb_tree_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for tree_spawn_scheduler: directed frame sequence with a queue of
// expected values, plus a second instance with short speed levels.
// -----------------------------------------------------------------------------
module tb_tree_spawn_scheduler;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          startOfFrame = 1'b0;
  logic          enable = 1'b0;
  logic [N-1:0]  hitIn = '0;
  logic [N-1:0]  hit_lv = '0;

  logic [N-1:0]    treeActive, treeActive_lv;
  logic [N*11-1:0] treeX, treeY, treeX_lv, treeY_lv;
  logic            passedPulse, hitPulse, passedPulse_lv, hitPulse_lv;
  logic [3:0]      speedLevel, speedLevel_lv;

  tree_spawn_scheduler dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .enable(enable),
    .hitIn(hitIn), .treeActive(treeActive), .treeX(treeX), .treeY(treeY),
    .passedPulse(passedPulse), .hitPulse(hitPulse), .speedLevel(speedLevel)
  );

  tree_spawn_scheduler #(.LEVEL_FRAMES(4)) dut_lv (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .enable(enable),
    .hitIn(hit_lv), .treeActive(treeActive_lv), .treeX(treeX_lv),
    .treeY(treeY_lv), .passedPulse(passedPulse_lv), .hitPulse(hitPulse_lv),
    .speedLevel(speedLevel_lv)
  );

  always #5 clk = ~clk;

  // Reference LFSR (Galois, taps 16,14,13,11) to predict spawn X.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  int passed_cnt = 0;
  int hit_cnt    = 0;
  always @(posedge clk) begin
    if (passedPulse) passed_cnt <= passed_cnt + 1;
    if (hitPulse)    hit_cnt    <= hit_cnt + 1;
  end

  int passes = 0;
  int checks = 0;
  int fails  = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];
  logic [15:0] snap;

  function automatic logic [31:0] xexp(input logic [15:0] l);
    logic [9:0] r;
    r = {1'b0, l[8:0]};
    if (r > 10'd508) r = r - 10'd509;
    return 32'd32 + 32'(r);
  endfunction

  function automatic logic [31:0] sl(input logic [N*11-1:0] v, input int i);
    return 32'(v[11*i +: 11]);
  endfunction

  task automatic sb_push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL sb_empty observed=%0d expected=<none>", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
    end
  endtask

  // One frame pulse; returns at the negedge after the sampling edge.
  task automatic frame();
    @(negedge clk);
    startOfFrame = 1'b1;
    snap = m_lfsr;
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, h0;
    logic [31:0] x0_exp;

    // Reset state
    sb_push("rst_active", 0); sb_push("rst_x", 0); sb_push("rst_y", 0);
    sb_push("rst_pulses", 0); sb_push("rst_level", 0);
    repeat (2) @(negedge clk);
    sb_pop(treeActive); sb_pop(32'(|treeX)); sb_pop(32'(|treeY));
    sb_pop({passedPulse, hitPulse}); sb_pop(speedLevel);
    reset = 1'b0;
    enable = 1'b1;

    // No activity during the first 59 frames
    p0 = passed_cnt; h0 = hit_cnt;
    sb_push("quiet_active", 0); sb_push("quiet_pulses", 0);
    repeat (59) frame();
    sb_pop(treeActive); sb_pop(32'(passed_cnt - p0 + hit_cnt - h0));

    // Frame 60: first spawn into slot 0
    frame();
    sb_push("spawn_active", 4'b0001); sb_push("spawn_y0", 0);
    sb_push("spawn_x0", xexp(snap)); sb_push("spawn_x0_range", 1);
    sb_pop(treeActive); sb_pop(sl(treeY, 0)); sb_pop(sl(treeX, 0));
    sb_pop(32'(sl(treeX, 0) >= 32 && sl(treeX, 0) <= 540));

    // Motion at base speed
    sb_push("y0_after64", 100);
    repeat (64) frame();
    sb_pop(sl(treeY, 0));
    sb_push("y0_after307", 479); sb_push("pool_full", 4'b1111);
    repeat (243) frame();
    sb_pop(sl(treeY, 0)); sb_pop(treeActive);

    // Frame 368: slot 0 exits, pool was full so no spawn yet
    sb_push("exit_active", 4'b1110); sb_push("exit_pulse", 1);
    sb_push("exit_pulse_end", 0);
    frame();
    sb_pop(treeActive); sb_pop(passedPulse);
    @(negedge clk);
    sb_pop(passedPulse);

    // Frame 369: freed slot 0 reused one frame later
    frame();
    sb_push("respawn_active", 4'b1111); sb_push("respawn_y0", 0);
    sb_push("respawn_x0", xexp(snap)); sb_push("y1_at369", 389);
    x0_exp = xexp(snap);
    sb_pop(treeActive); sb_pop(sl(treeY, 0)); sb_pop(sl(treeX, 0));
    sb_pop(sl(treeY, 1));

    // Up to frame 427: slot 1 at Yfp=30700
    sb_push("y1_at427", 479);
    repeat (58) frame();
    sb_pop(sl(treeY, 1));

    // Frame 428: hit on slot 1 as it would exit, hitIn held 5 cycles
    p0 = passed_cnt; h0 = hit_cnt;
    sb_push("hit_active", 4'b1101); sb_push("hit_pulse", 1);
    sb_push("hit_no_passed", 0);
    @(negedge clk);
    startOfFrame = 1'b1;
    hitIn = 4'b0010;
    @(negedge clk);
    startOfFrame = 1'b0;
    sb_pop(treeActive); sb_pop(hitPulse); sb_pop(passedPulse);
    repeat (4) @(negedge clk);
    hitIn = '0;
    sb_push("hit_pulse_count", 1); sb_push("hit_passed_count", 0);
    sb_pop(32'(hit_cnt - h0)); sb_pop(32'(passed_cnt - p0));

    // Freeze for 100 frames with all hits asserted
    enable = 1'b0;
    hitIn = 4'b1111;
    p0 = passed_cnt; h0 = hit_cnt;
    sb_push("frz_active", 4'b1101); sb_push("frz_y0", 92);
    sb_push("frz_y2", 387); sb_push("frz_y3", 293);
    sb_push("frz_x0", x0_exp); sb_push("frz_pulses", 0);
    repeat (100) frame();
    hitIn = '0;
    sb_pop(treeActive); sb_pop(sl(treeY, 0)); sb_pop(sl(treeY, 2));
    sb_pop(sl(treeY, 3)); sb_pop(sl(treeX, 0));
    sb_pop(32'(passed_cnt - p0 + hit_cnt - h0));

    // Re-enable: motion resumes, held spawn timer fires into slot 1
    enable = 1'b1;
    frame();
    sb_push("resume_y0", 93); sb_push("resume_y2", 389);
    sb_push("resume_active", 4'b1111); sb_push("resume_y1", 0);
    sb_push("resume_x1", xexp(snap)); sb_push("resume_level", 0);
    sb_pop(sl(treeY, 0)); sb_pop(sl(treeY, 2)); sb_pop(treeActive);
    sb_pop(sl(treeY, 1)); sb_pop(sl(treeX, 1)); sb_pop(speedLevel);

    // Reset coincident with a frame pulse discards everything
    sb_push("mid_rst_active", 0); sb_push("mid_rst_y", 0);
    sb_push("mid_rst_x", 0); sb_push("mid_rst_lv_level", 0);
    @(negedge clk);
    reset = 1'b1;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    sb_pop(treeActive); sb_pop(32'(|treeY)); sb_pop(32'(|treeX));
    sb_pop(speedLevel_lv);
    reset = 1'b0;

    // Short levels: speed climbs 16 per 4 frames and saturates
    sb_push("lv_level_3", 0);
    repeat (3) frame();
    sb_pop(speedLevel_lv);
    sb_push("lv_level_4", 1);
    frame();
    sb_pop(speedLevel_lv);
    sb_push("lv_level_56", 14);
    repeat (52) frame();
    sb_pop(speedLevel_lv);
    sb_push("lv_level_60", 15); sb_push("lv_spawn", 4'b0001);
    repeat (4) frame();
    sb_pop(speedLevel_lv); sb_pop(treeActive_lv);
    sb_push("lv_level_sat", 15); sb_push("lv_y0_sat_speed", 320);
    sb_push("dflt_level", 0);
    repeat (64) frame();
    sb_pop(speedLevel_lv); sb_pop(sl(treeY_lv, 0)); sb_pop(speedLevel);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
